crc_serial_encoder: RTL and testbench

Parametrised bit-serial CRC encoder for the USB transmit path, sitting between the protocol handler and the bit-stuffer. It loads a packet of runtime-selectable length and shifts it out LSB-first. The first `SKIP_BITS` (PID) bits pass through uncovered by the CRC. The complemented CRC remainder is appended after the packet. Transfers are throttled by the bit-stuffer's ready. One instance per CRC flavour: CRC5 for tokens, CRC16 for data.

---
 rtl/crc_serial_encoder.sv | 174 +++++++++++++++++
 tb/tb_crc_serial_encoder.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_serial_encoder.sv
// Bit-serial CRC encoder: shifts a packet out LSB-first and appends the complemented CRC.
// Optional feature macro CRC_ENC_BYPASS_EN adds a crc_bypass input that suppresses the CRC tail.
module crc_serial_encoder #(
    parameter int               PKT_W     = 72,
    parameter int               CRC_W     = 16,
    parameter logic [CRC_W-1:0] POLY      = 16'h8005,
    parameter int               SKIP_BITS = 8,
    parameter int               LEN_W     = $clog2(PKT_W + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             pkt_ready,
    input  logic [PKT_W-1:0] pkt_in,
    input  logic [LEN_W-1:0] pkt_len,
`ifdef CRC_ENC_BYPASS_EN
    input  logic             crc_bypass,
`endif
    input  logic             bs_ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int                FIDX_W   = $clog2(CRC_W);
    localparam logic [LEN_W-1:0]  SKIP_LEN = LEN_W'(SKIP_BITS);
    localparam logic [LEN_W-1:0]  MAX_LEN  = LEN_W'(PKT_W);
    localparam logic [FIDX_W-1:0] FIDX_TOP = FIDX_W'(CRC_W - 1);

    typedef enum logic [1:0] {IDLE, SKIP, DATA, FLUSH} state_t;

    state_t             state_q, state_d;
    logic [PKT_W-1:0]   shift_q, shift_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic [FIDX_W-1:0]  fidx_q, fidx_d;
    logic               done_q, done_d;
    logic               xfer;
    logic               last_pkt;
    logic               no_crc;
    logic [LEN_W-1:0]   cnt_inc;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        if (l < SKIP_LEN)
            return SKIP_LEN;
        else if (l > MAX_LEN)
            return MAX_LEN;
        else
            return l;
    endfunction

    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] r, input logic b);
        logic fb;
        fb = b ^ r[CRC_W-1];
        return {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    endfunction

`ifdef CRC_ENC_BYPASS_EN
    logic bypass_q, bypass_d;
    assign no_crc = bypass_q;
`else
    assign no_crc = 1'b0;
`endif

    assign busy      = (state_q != IDLE);
    assign out_valid = busy;
    assign xfer      = busy && bs_ready;
    assign cnt_inc   = cnt_q + LEN_W'(1);
    assign last_pkt  = (cnt_inc == len_q);
    // During FLUSH the frozen remainder is sent MSB-first, inverted.
    assign out_bit   = (state_q == FLUSH) ? ~crc_q[fidx_q] : (busy & shift_q[0]);
    assign done      = done_q;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        crc_d    = crc_q;
        fidx_d   = fidx_q;
        done_d   = 1'b0;
`ifdef CRC_ENC_BYPASS_EN
        bypass_d = bypass_q;
`endif
        case (state_q)
            IDLE: begin
                if (pkt_ready) begin
                    shift_d  = pkt_in;
                    len_d    = clamp_len(pkt_len);
                    crc_d    = '1;
                    cnt_d    = '0;
                    fidx_d   = FIDX_TOP;
`ifdef CRC_ENC_BYPASS_EN
                    bypass_d = crc_bypass;
`endif
                    state_d  = SKIP;
                end
            end
            SKIP: begin
                if (xfer) begin
                    shift_d = shift_q >> 1;
                    cnt_d   = cnt_inc;
                    if (cnt_inc == SKIP_LEN) begin
                        if (!last_pkt) begin
                            state_d = DATA;
                        end else if (no_crc) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = FLUSH;
                        end
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    crc_d   = crc_step(crc_q, shift_q[0]);
                    shift_d = shift_q >> 1;
                    cnt_d   = cnt_inc;
                    if (last_pkt) begin
                        if (no_crc) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (xfer) begin
                    if (fidx_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        fidx_d = fidx_q - FIDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            crc_q    <= '1;
            fidx_q   <= '0;
            done_q   <= 1'b0;
`ifdef CRC_ENC_BYPASS_EN
            bypass_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            crc_q    <= crc_d;
            fidx_q   <= fidx_d;
            done_q   <= done_d;
`ifdef CRC_ENC_BYPASS_EN
            bypass_q <= bypass_d;
`endif
        end
    end

    // Packet data is only observed while busy, so the shifter needs no reset.
    always_ff @(posedge clock) begin
        shift_q <= shift_d;
    end

endmodule

// File: tb/tb_crc_serial_encoder.sv
// Scoreboard bench for crc_serial_encoder: a CRC16 instance plus a CRC5 instance.
// Exercises the CRC_ENC_BYPASS_EN path when that macro is defined.
module tb_crc_serial_encoder;

    logic        clock;
    logic        reset_n;
    logic        pkt_ready;
    logic [71:0] pkt_in;
    logic [6:0]  pkt_len;
    logic        bs_ready;
    logic        out_bit, out_valid, busy, done;

    logic        pkt_ready5;
    logic [18:0] pkt_in5;
    logic [4:0]  pkt_len5;
    logic        bs_ready5;
    logic        out_bit5, out_valid5, busy5, done5;
`ifdef CRC_ENC_BYPASS_EN
    logic        crc_bypass;
    logic        crc_bypass5;
`endif

    int checks = 0;
    int errors = 0;
    logic exp_q[$];
    logic obs_q[$];

    crc_serial_encoder u_dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .pkt_ready (pkt_ready),
        .pkt_in    (pkt_in),
        .pkt_len   (pkt_len),
`ifdef CRC_ENC_BYPASS_EN
        .crc_bypass(crc_bypass),
`endif
        .bs_ready  (bs_ready),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    crc_serial_encoder #(
        .PKT_W(19), .CRC_W(5), .POLY(5'h05), .SKIP_BITS(8)
    ) u_dut5 (
        .clock     (clock),
        .reset_n   (reset_n),
        .pkt_ready (pkt_ready5),
        .pkt_in    (pkt_in5),
        .pkt_len   (pkt_len5),
`ifdef CRC_ENC_BYPASS_EN
        .crc_bypass(crc_bypass5),
`endif
        .bs_ready  (bs_ready5),
        .out_bit   (out_bit5),
        .out_valid (out_valid5),
        .busy      (busy5),
        .done      (done5)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: full packet bits, then complemented CRC16 (init ones) over bits 8..len-1.
    task automatic push_expected(input logic [71:0] pkt, input int len);
        logic [15:0] r;
        logic        fb;
        for (int i = 0; i < len; i++) exp_q.push_back(pkt[i]);
        r = 16'hFFFF;
        for (int i = 8; i < len; i++) begin
            fb = pkt[i] ^ r[15];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end
        for (int i = 15; i >= 0; i--) exp_q.push_back(~r[i]);
    endtask

    task automatic load(input logic [71:0] pkt, input logic [6:0] len);
        pkt_in    = pkt;
        pkt_len   = len;
        pkt_ready = 1'b1;
        @(posedge clock); #1;
        pkt_ready = 1'b0;
    endtask

    // Drives bs_ready per mode and records accepted bits; returns the cycle done was seen.
    // mode 0: always ready, 1: random, 2: 2-cycle stalls at boundaries, 3: ready + stray load.
    task automatic collect(input int mode, input int len, input int max_cycles,
                           output int done_cyc, output int unstable);
        int   n_acc, stall_left, last_st;
        logic prev_bit;
        bit   prev_stalled;
        n_acc = 0; stall_left = 0; last_st = -1; prev_bit = 1'b0; prev_stalled = 1'b0;
        done_cyc = -1; unstable = 0;
        for (int cyc = 1; cyc <= max_cycles; cyc++) begin
            pkt_ready = (mode == 3 && cyc == 5);
            if (pkt_ready) begin
                pkt_in  = '1;
                pkt_len = 7'd72;
            end
            case (mode)
                1: bs_ready = ($urandom_range(0, 2) != 0);
                2: begin
                    if (stall_left > 0) begin
                        bs_ready = 1'b0;
                        stall_left--;
                    end else if ((n_acc == 7 || n_acc == len - 1 || n_acc == len + 15)
                                 && n_acc != last_st) begin
                        bs_ready   = 1'b0;
                        stall_left = 1;
                        last_st    = n_acc;
                    end else begin
                        bs_ready = 1'b1;
                    end
                end
                default: bs_ready = 1'b1;
            endcase
            @(negedge clock);
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (prev_stalled && out_valid && out_bit !== prev_bit) unstable++;
            prev_stalled = out_valid && !bs_ready;
            prev_bit     = out_bit;
            if (out_valid && bs_ready) begin
                obs_q.push_back(out_bit);
                n_acc++;
            end
            @(posedge clock); #1;
        end
        pkt_ready = 1'b0;
        bs_ready  = 1'b1;
    endtask

    task automatic test_reset_state;
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL rst_done got %b want 0", done); end
        checks++; if (out_bit !== 1'b0)   begin errors++; $display("FAIL rst_bit got %b want 0", out_bit); end
        checks++; if (out_valid5 !== 1'b0) begin errors++; $display("FAIL rst_valid5 got %b want 0", out_valid5); end
    endtask

    task automatic test_pid_only_crc16;
        logic [23:0] v;
        int dc, un;
        logic e, o;
        v = {16'h0000, 8'hC3};
        for (int i = 0; i < 24; i++) exp_q.push_back(v[i]);
        load(72'hC3, 7'd8);
        collect(0, 8, 60, dc, un);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL pid16_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL pid16_bit%0d got %b want %b", i, o, e); end
        end
        checks++; if (dc != 25) begin errors++; $display("FAIL pid16_done_cycle got %0d want 25", dc); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_crc5;
        logic [23:0] v;
        logic e, o;
        int dc;
        v = {5'b00010, 11'b0, 8'hE1};
        for (int i = 0; i < 24; i++) exp_q.push_back(v[i]);
        pkt_in5 = 19'h000E1; pkt_len5 = 5'd19; pkt_ready5 = 1'b1;
        @(posedge clock); #1;
        pkt_ready5 = 1'b0;
        dc = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clock);
            if (done5) begin dc = cyc; break; end
            if (out_valid5 && bs_ready5) obs_q.push_back(out_bit5);
            @(posedge clock); #1;
        end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL crc5_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL crc5_bit%0d got %b want %b", i, o, e); end
        end
        checks++; if (dc != 25) begin errors++; $display("FAIL crc5_done_cycle got %0d want 25", dc); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_random_stall;
        logic [95:0] tmp;
        logic [71:0] pkt;
        logic e, o;
        int dc, un;
        tmp = {$urandom(), $urandom(), $urandom()};
        pkt = tmp[71:0];
        for (int run = 0; run < 2; run++) begin
            push_expected(pkt, 72);
            load(pkt, 7'd72);
            collect(run, 72, 600, dc, un);
            checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL stall%0d_count got %0d want %0d", run, obs_q.size(), exp_q.size()); end
            for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                checks++; if (o !== e) begin errors++; $display("FAIL stall%0d_bit%0d got %b want %b", run, i, o, e); end
            end
            checks++; if (un != 0) begin errors++; $display("FAIL stall%0d_stable got %0d changes want 0", run, un); end
            if (run == 0) begin
                checks++; if (dc != 89) begin errors++; $display("FAIL full_done_cycle got %0d want 89", dc); end
            end else begin
                checks++; if (dc < 89) begin errors++; $display("FAIL rand_done_cycle got %0d want >=89", dc); end
            end
            exp_q.delete(); obs_q.delete();
        end
    endtask

    task automatic test_boundary_stall;
        logic [71:0] pkt;
        logic e, o;
        int dc, un;
        pkt = {40'h0, 32'hA5C3_17E9};
        push_expected(pkt, 40);
        load(pkt, 7'd40);
        collect(2, 40, 200, dc, un);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL bnd_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL bnd_bit%0d got %b want %b", i, o, e); end
        end
        checks++; if (un != 0)  begin errors++; $display("FAIL bnd_stable got %0d changes want 0", un); end
        checks++; if (dc != 63) begin errors++; $display("FAIL bnd_done_cycle got %0d want 63", dc); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_clamp;
        logic [95:0] tmp;
        logic [71:0] pkt;
        logic e, o;
        int dc, un;
        // Length 0 clamps up to the PID length; length 100 clamps down to 72.
        push_expected(72'h5A, 8);
        load(72'h5A, 7'd0);
        collect(0, 8, 60, dc, un);
        checks++; if (dc != 25) begin errors++; $display("FAIL clamp_lo_done got %0d want 25", dc); end
        tmp = {$urandom(), $urandom(), $urandom()};
        pkt = tmp[71:0];
        push_expected(pkt, 72);
        load(pkt, 7'd100);
        collect(0, 72, 200, dc, un);
        checks++; if (dc != 89) begin errors++; $display("FAIL clamp_hi_done got %0d want 89", dc); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL clamp_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL clamp_bit%0d got %b want %b", i, o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid;
        logic [71:0] pkt;
        logic e, o;
        int dc, un;
        load(72'hFF_FFFF_FFFF, 7'd40);
        repeat (12) @(posedge clock);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", busy); end
        reset_n = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL mid_rst_done got %b want 0", done); end
        checks++; if (out_bit !== 1'b0)   begin errors++; $display("FAIL mid_rst_bit got %b want 0", out_bit); end
        @(posedge clock); @(posedge clock); #1;
        reset_n = 1'b1;
        pkt = {40'h0, 32'h1234_5678};
        push_expected(pkt, 32);
        load(pkt, 7'd32);
        collect(0, 32, 100, dc, un);
        checks++; if (dc != 49) begin errors++; $display("FAIL after_rst_done got %0d want 49", dc); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL after_rst_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL after_rst_bit%0d got %b want %b", i, o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_busy_ignored;
        logic [71:0] pkt;
        logic e, o;
        int dc, un;
        pkt = {48'h0, 24'h3C_0F_2D};
        push_expected(pkt, 24);
        load(pkt, 7'd24);
        collect(3, 24, 100, dc, un);
        checks++; if (dc != 41) begin errors++; $display("FAIL ignore_done got %0d want 41", dc); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL ignore_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL ignore_bit%0d got %b want %b", i, o, e); end
        end
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_idle got %b want 0", busy); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back;
        logic [71:0] pa, pb;
        logic e, o;
        int dca, dcb, un;
        pa = {56'h0, 16'hBEEF};
        pb = {52'h0, 20'h9_1A2B};
        push_expected(pa, 16);
        push_expected(pb, 20);
        load(pa, 7'd16);
        collect(0, 16, 100, dca, un);
        // Still in the done cycle: the new load must be taken on the next edge.
        load(pb, 7'd20);
        collect(0, 20, 100, dcb, un);
        checks++; if (dca != 33) begin errors++; $display("FAIL b2b_done_a got %0d want 33", dca); end
        checks++; if (dcb != 37) begin errors++; $display("FAIL b2b_done_b got %0d want 37", dcb); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL b2b_bit%0d got %b want %b", i, o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

`ifdef CRC_ENC_BYPASS_EN
    task automatic test_bypass;
        logic [7:0] v;
        logic e, o;
        int dc, un;
        v = 8'hD2;
        for (int i = 0; i < 8; i++) exp_q.push_back(v[i]);
        crc_bypass = 1'b1;
        load(72'hD2, 7'd8);
        crc_bypass = 1'b0;
        collect(0, 8, 40, dc, un);
        checks++; if (dc != 9) begin errors++; $display("FAIL bypass_done got %0d want 9", dc); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL bypass_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL bypass_bit%0d got %b want %b", i, o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask
`endif

    initial begin
        reset_n    = 1'b0;
        pkt_ready  = 1'b0;
        pkt_in     = '0;
        pkt_len    = '0;
        bs_ready   = 1'b1;
        pkt_ready5 = 1'b0;
        pkt_in5    = '0;
        pkt_len5   = '0;
        bs_ready5  = 1'b1;
`ifdef CRC_ENC_BYPASS_EN
        crc_bypass  = 1'b0;
        crc_bypass5 = 1'b0;
`endif
        repeat (3) @(posedge clock);
        test_reset_state();
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        test_pid_only_crc16();
        test_crc5();
        test_random_stall();
        test_boundary_stall();
        test_clamp();
        test_reset_mid();
        test_busy_ignored();
        test_back_to_back();
`ifdef CRC_ENC_BYPASS_EN
        test_bypass();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
